// File: rtl/vec_exec_pkg.sv
// Shared definitions for the vector execution unit.
// Contents:
//   OP_VMUL, OP_VADD, OP_VMAC, OP_VADDR  opcode encodings (instr[29:26])
//   stage_ctrl_t                         per-stage control word (valid, op, last, err)
//   lane_lo()                            lowest bit index of a lane inside a packed vector
//   op_is_legal()                        true for the four defined opcodes
package vec_exec_pkg;

   localparam logic [3:0] OP_VMUL  = 4'b0001;
   localparam logic [3:0] OP_VADD  = 4'b0010;
   localparam logic [3:0] OP_VMAC  = 4'b0011;
   localparam logic [3:0] OP_VADDR = 4'b0100;

   typedef struct packed {
      logic       valid;
      logic [3:0] op;
      logic       last;
      logic       err;
   } stage_ctrl_t;

   function automatic int lane_lo(input int lane, input int width);
      return lane * width;
   endfunction

   function automatic logic op_is_legal(input logic [3:0] op);
      return (op == OP_VMUL) || (op == OP_VADD) || (op == OP_VMAC) || (op == OP_VADDR);
   endfunction

endpackage

// File: rtl/vec_lane.sv
// One lane of the vector execution unit: stage-2 arithmetic and the MAC accumulator.
// Ports:
//   clk, rst          clock, asynchronous active-low reset
//   en                pipeline advance enable
//   op, a, b          stage-1 opcode and this lane's operands
//   mac_beat          stage 2 holds a valid VMAC beat
//   mac_last          that beat closes the MAC sequence
//   res               stage-3 lane result (accumulated on the closing MAC beat)
module vec_lane
   import vec_exec_pkg::*;
#(
   parameter int DATA_W = 32
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              en,
   input  logic [3:0]        op,
   input  logic [DATA_W-1:0] a,
   input  logic [DATA_W-1:0] b,
   input  logic              mac_beat,
   input  logic              mac_last,
   output logic [DATA_W-1:0] res
);

   logic [DATA_W-1:0] p_next;
   logic [DATA_W-1:0] p_q;
   logic [DATA_W-1:0] acc;

   // Per-lane operation; VADDR and illegal opcodes contribute nothing
   always_comb begin
      p_next = '0;
      case (op)
         OP_VMUL, OP_VMAC: p_next = a * b;
         OP_VADD:          p_next = a + b;
         default:          p_next = '0;
      endcase
   end

   // Stage-2 product register
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         p_q <= '0;
      end else if (en) begin
         p_q <= p_next;
      end
   end

   // Accumulator folds non-final MAC beats and empties as the final beat leaves
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         acc <= '0;
      end else if (en && mac_beat) begin
         acc <= mac_last ? '0 : acc + p_q;
      end
   end

   assign res = (mac_beat && mac_last) ? acc + p_q : p_q;

endmodule

// File: rtl/vec_exec_unit.sv
// Parametrised vector execution unit: 3-stage valid/ready pipeline with
// per-lane multiply/add, multi-beat multiply-accumulate, pairwise sums and
// strided address generation.
// Ports:
//   clk, rst                  clock, asynchronous active-low reset
//   in_valid/in_ready         operand beat handshake
//   opcode, last              operation and MAC sequence terminator
//   vec_a, vec_b              packed lane operands
//   base_addr, stride         address generator inputs
//   out_valid/out_ready       result handshake
//   mul_res, sum_res          lane results and pairwise sums
//   addr_res                  base_addr + j*stride per pair slot
//   mac_beats, op_err         beats folded into a MAC result, illegal-opcode flag
// LANES must be even and at least 2.
module vec_exec_unit
   import vec_exec_pkg::*;
#(
   parameter int LANES  = 8,
   parameter int DATA_W = 32,
   parameter int ADDR_W = 32,
   parameter int CNT_W  = 8
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic                        in_valid,
   output logic                        in_ready,
   input  logic [3:0]                  opcode,
   input  logic                        last,
   input  logic [LANES*DATA_W-1:0]     vec_a,
   input  logic [LANES*DATA_W-1:0]     vec_b,
   input  logic [ADDR_W-1:0]           base_addr,
   input  logic [ADDR_W-1:0]           stride,
   output logic                        out_valid,
   input  logic                        out_ready,
   output logic [LANES*DATA_W-1:0]     mul_res,
   output logic [(LANES/2)*DATA_W-1:0] sum_res,
   output logic [(LANES/2)*ADDR_W-1:0] addr_res,
   output logic [CNT_W-1:0]            mac_beats,
   output logic                        op_err
);

   logic                        ready_q;
   logic                        en;
   logic                        mac_s2;
   logic                        emit_s2;
   stage_ctrl_t                 s1;
   stage_ctrl_t                 s2;
   logic [LANES*DATA_W-1:0]     s1_a;
   logic [LANES*DATA_W-1:0]     s1_b;
   logic [LANES*DATA_W-1:0]     lane_res;
   logic [(LANES/2)*DATA_W-1:0] pair_sum;
   logic [(LANES/2)*ADDR_W-1:0] addr_gen;
   logic [ADDR_W-1:0]           s1_base;
   logic [ADDR_W-1:0]           s1_stride;
   logic [ADDR_W-1:0]           s2_base;
   logic [ADDR_W-1:0]           s2_stride;
   logic [CNT_W-1:0]            beat_cnt;
   logic [CNT_W-1:0]            cnt_inc;

   // The whole pipeline moves together unless a result is waiting on the consumer
   assign en       = !out_valid || out_ready;
   assign in_ready = ready_q && en;

   // Non-final MAC beats are absorbed into the accumulators and produce no output
   assign mac_s2  = s2.valid && (s2.op == OP_VMAC);
   assign emit_s2 = s2.valid && !(mac_s2 && !s2.last);
   assign cnt_inc = (beat_cnt == '1) ? beat_cnt : beat_cnt + CNT_W'(1);

   // Keeps in_ready low until the first clock edge after reset release
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         ready_q <= 1'b0;
      end else begin
         ready_q <= 1'b1;
      end
   end

   // Stage 1 captures the beat; the legality check is resolved here
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         s1        <= '0;
         s1_a      <= '0;
         s1_b      <= '0;
         s1_base   <= '0;
         s1_stride <= '0;
      end else if (en) begin
         s1        <= '{valid: in_valid && ready_q, op: opcode, last: last,
                        err: !op_is_legal(opcode)};
         s1_a      <= vec_a;
         s1_b      <= vec_b;
         s1_base   <= base_addr;
         s1_stride <= stride;
      end
   end

   // Stage 2 control travels alongside the lane product registers
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         s2        <= '0;
         s2_base   <= '0;
         s2_stride <= '0;
      end else if (en) begin
         s2        <= s1;
         s2_base   <= s1_base;
         s2_stride <= s1_stride;
      end
   end

   for (genvar i = 0; i < LANES; i++) begin : g_lane
      vec_lane #(.DATA_W(DATA_W)) u_lane (
         .clk      (clk),
         .rst      (rst),
         .en       (en),
         .op       (s1.op),
         .a        (s1_a[lane_lo(i, DATA_W) +: DATA_W]),
         .b        (s1_b[lane_lo(i, DATA_W) +: DATA_W]),
         .mac_beat (mac_s2),
         .mac_last (s2.last),
         .res      (lane_res[lane_lo(i, DATA_W) +: DATA_W])
      );
   end

   for (genvar j = 0; j < LANES/2; j++) begin : g_pair
      assign pair_sum[lane_lo(j, DATA_W) +: DATA_W] =
         lane_res[lane_lo(2*j, DATA_W) +: DATA_W] + lane_res[lane_lo(2*j+1, DATA_W) +: DATA_W];
      assign addr_gen[lane_lo(j, ADDR_W) +: ADDR_W] = s2_base + ADDR_W'(j) * s2_stride;
   end

   // Output stage and MAC beat counter; the counter empties with the final beat
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         out_valid <= 1'b0;
         mul_res   <= '0;
         sum_res   <= '0;
         addr_res  <= '0;
         mac_beats <= '0;
         op_err    <= 1'b0;
         beat_cnt  <= '0;
      end else if (en) begin
         out_valid <= emit_s2;
         if (mac_s2) begin
            beat_cnt <= s2.last ? '0 : cnt_inc;
         end
         if (emit_s2) begin
            mul_res   <= lane_res;
            sum_res   <= pair_sum;
            addr_res  <= addr_gen;
            mac_beats <= mac_s2 ? cnt_inc : '0;
            op_err    <= s2.err;
         end
      end
   end

endmodule

// File: tb/tb_vec_exec_unit.sv
// Self-checking bench for vec_exec_unit (LANES=8, DATA_W=32, ADDR_W=32, CNT_W=8).
// Expected results are queued when a beat is accepted and compared when the
// unit presents a result.
module tb_vec_exec_unit;

   localparam int LANES = 8;
   localparam int DW    = 32;
   localparam int AW    = 32;
   localparam int CW    = 8;

   typedef struct {
      logic [LANES*DW-1:0]     mul;
      logic [(LANES/2)*DW-1:0] sum;
      logic [(LANES/2)*AW-1:0] addr;
      logic [CW-1:0]           beats;
      logic                    err;
   } exp_t;

   logic                    clk = 1'b0;
   logic                    rst;
   logic                    in_valid;
   logic                    in_ready;
   logic [3:0]              opcode;
   logic                    last;
   logic [LANES*DW-1:0]     vec_a;
   logic [LANES*DW-1:0]     vec_b;
   logic [AW-1:0]           base_addr;
   logic [AW-1:0]           stride;
   logic                    out_valid;
   logic                    out_ready;
   logic [LANES*DW-1:0]     mul_res;
   logic [(LANES/2)*DW-1:0] sum_res;
   logic [(LANES/2)*AW-1:0] addr_res;
   logic [CW-1:0]           mac_beats;
   logic                    op_err;

   int                      tests = 0;
   int                      fails = 0;
   exp_t                    sb[$];
   logic [DW-1:0]           model_acc[LANES];
   int                      model_cnt = 0;
   logic                    stall_prev = 1'b0;
   logic [LANES*DW-1:0]     held_mul;
   logic [(LANES/2)*DW-1:0] held_sum;

   vec_exec_unit #(.LANES(LANES), .DATA_W(DW), .ADDR_W(AW), .CNT_W(CW)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .opcode    (opcode),
      .last      (last),
      .vec_a     (vec_a),
      .vec_b     (vec_b),
      .base_addr (base_addr),
      .stride    (stride),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .mul_res   (mul_res),
      .sum_res   (sum_res),
      .addr_res  (addr_res),
      .mac_beats (mac_beats),
      .op_err    (op_err)
   );

   always #5 clk = ~clk;

   // Reference per-lane operation
   function automatic logic [DW-1:0] lane_op(input logic [3:0] op, input logic [DW-1:0] a,
                                             input logic [DW-1:0] b);
      case (op)
         4'd1, 4'd3: return a * b;
         4'd2:       return a + b;
         default:    return '0;
      endcase
   endfunction

   // Drives one beat, waits for acceptance, then updates the reference model
   task automatic applyStimulus(input logic [3:0] op, input logic [LANES*DW-1:0] a,
                                input logic [LANES*DW-1:0] b, input logic lst,
                                input logic [AW-1:0] base, input logic [AW-1:0] strd);
      logic   accepted;
      exp_t   e;
      logic [DW-1:0] p;
      opcode    = op;
      vec_a     = a;
      vec_b     = b;
      last      = lst;
      base_addr = base;
      stride    = strd;
      in_valid  = 1'b1;
      accepted  = 1'b0;
      for (int k = 0; k < 100; k++) begin
         @(negedge clk);
         if (in_ready === 1'b1) begin
            accepted = 1'b1;
            break;
         end
      end
      if (!accepted) begin
         tests++;
         fails++;
         $error("[TB] FAIL accept_timeout in_ready got %b required 1", in_ready);
         in_valid = 1'b0;
         return;
      end
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      if (op == 4'd3 && !lst) begin
         for (int i = 0; i < LANES; i++)
            model_acc[i] = model_acc[i] + lane_op(op, a[i*DW +: DW], b[i*DW +: DW]);
         model_cnt = (model_cnt == 255) ? 255 : model_cnt + 1;
         return;
      end
      for (int i = 0; i < LANES; i++) begin
         p = lane_op(op, a[i*DW +: DW], b[i*DW +: DW]);
         if (op == 4'd3) begin
            e.mul[i*DW +: DW] = model_acc[i] + p;
            model_acc[i] = '0;
         end else begin
            e.mul[i*DW +: DW] = p;
         end
      end
      for (int j = 0; j < LANES/2; j++) begin
         e.sum[j*DW +: DW]  = e.mul[2*j*DW +: DW] + e.mul[(2*j+1)*DW +: DW];
         e.addr[j*AW +: AW] = base + AW'(j) * strd;
      end
      if (op == 4'd3) begin
         e.beats   = CW'((model_cnt == 255) ? 255 : model_cnt + 1);
         model_cnt = 0;
      end else begin
         e.beats = '0;
      end
      e.err = !(op inside {4'd1, 4'd2, 4'd3, 4'd4});
      sb.push_back(e);
   endtask

   // Compares one presented result against the expected entry
   task automatic checkOutput(input exp_t e);
      tests++;
      assert (mul_res === e.mul) else begin
         fails++;
         $error("[TB] FAIL mul_res got %h required %h", mul_res, e.mul);
      end
      tests++;
      assert (sum_res === e.sum) else begin
         fails++;
         $error("[TB] FAIL sum_res got %h required %h", sum_res, e.sum);
      end
      tests++;
      assert (addr_res === e.addr) else begin
         fails++;
         $error("[TB] FAIL addr_res got %h required %h", addr_res, e.addr);
      end
      tests++;
      assert (mac_beats === e.beats) else begin
         fails++;
         $error("[TB] FAIL mac_beats got %0d required %0d", mac_beats, e.beats);
      end
      tests++;
      assert (op_err === e.err) else begin
         fails++;
         $error("[TB] FAIL op_err got %b required %b", op_err, e.err);
      end
   endtask

   task automatic checkBit(input string tag, input logic got, input logic req);
      tests++;
      assert (got === req) else begin
         fails++;
         $error("[TB] FAIL %s got %b required %b", tag, got, req);
      end
   endtask

   task automatic idle(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   // Result monitor: pops the scoreboard on every transfer and checks stall stability
   always @(negedge clk) begin
      if (rst === 1'b1) begin
         if (stall_prev) begin
            tests++;
            assert (out_valid === 1'b1 && mul_res === held_mul && sum_res === held_sum) else begin
               fails++;
               $error("[TB] FAIL stall_hold got valid=%b mul=%h required mul=%h", out_valid, mul_res, held_mul);
            end
         end
         if (out_valid === 1'b1 && out_ready === 1'b1) begin
            if (sb.size() == 0) begin
               tests++;
               fails++;
               $error("[TB] FAIL unexpected_result got mul=%h required no result", mul_res);
            end else begin
               checkOutput(sb.pop_front());
            end
         end
         stall_prev = (out_valid === 1'b1) && (out_ready === 1'b0);
         held_mul   = mul_res;
         held_sum   = sum_res;
      end else begin
         stall_prev = 1'b0;
      end
   end

   initial begin
      logic [LANES*DW-1:0] va, vb, v3, v4;
      for (int i = 0; i < LANES; i++) model_acc[i] = '0;
      for (int i = 0; i < LANES; i++) begin
         v3[i*DW +: DW] = 32'd3;
         v4[i*DW +: DW] = 32'd4;
      end
      rst = 1'b0; in_valid = 1'b0; out_ready = 1'b1; opcode = '0; last = 1'b0;
      vec_a = '0; vec_b = '0; base_addr = '0; stride = '0;

      // Reset state
      idle(2);
      checkBit("reset_in_ready", in_ready, 1'b0);
      checkBit("reset_out_valid", out_valid, 1'b0);
      checkBit("reset_outputs_zero", (mul_res == '0) && (sum_res == '0) && (addr_res == '0)
               && (mac_beats == '0) && !op_err, 1'b1);
      rst = 1'b1;
      #1;
      checkBit("release_in_ready_low", in_ready, 1'b0);
      idle(1);
      checkBit("release_in_ready_high", in_ready, 1'b1);

      // VMUL, a[i]=i+1, b[i]=2, with exact latency
      for (int i = 0; i < LANES; i++) begin
         va[i*DW +: DW] = DW'(i + 1);
         vb[i*DW +: DW] = 32'd2;
      end
      applyStimulus(4'd1, va, vb, 1'b0, 32'h100, 32'h4);
      @(negedge clk); checkBit("latency_c1", out_valid, 1'b0);
      @(negedge clk); checkBit("latency_c2", out_valid, 1'b0);
      @(negedge clk); checkBit("latency_c3", out_valid, 1'b1);
      idle(2);

      // VADD wrap and address wrap
      va = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, 32'hFFFF_FFFF};
      vb = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, 32'h1};
      applyStimulus(4'd2, va, vb, 1'b0, 32'hFFFF_FFF0, 32'h8);
      // VADDR
      applyStimulus(4'd4, va, vb, 1'b0, $urandom, $urandom);

      // VMAC over 3 beats then a single-beat MAC
      applyStimulus(4'd3, v3, v4, 1'b0, 32'h0, 32'h10);
      applyStimulus(4'd3, v3, v4, 1'b0, 32'h0, 32'h10);
      applyStimulus(4'd3, v3, v4, 1'b1, 32'h0, 32'h10);
      applyStimulus(4'd3, v3, v4, 1'b1, 32'h40, 32'h10);

      // Non-MAC op in the middle of a MAC sequence
      for (int i = 0; i < LANES; i++) begin
         va[i*DW +: DW] = $urandom_range(1, 1000);
         vb[i*DW +: DW] = $urandom_range(1, 1000);
      end
      applyStimulus(4'd3, va, vb, 1'b0, 32'h0, 32'h0);
      applyStimulus(4'd2, {8{$urandom}}, {8{$urandom}}, 1'b0, $urandom, $urandom);
      applyStimulus(4'd3, vb, va, 1'b1, 32'h200, 32'h20);

      // Illegal opcode then a clean VMUL
      applyStimulus(4'hF, {8{$urandom}}, {8{$urandom}}, 1'b0, $urandom, $urandom);
      applyStimulus(4'd1, {8{$urandom}}, {8{$urandom}}, 1'b0, $urandom, $urandom);
      idle(6);

      // Backpressure with a continuous stream
      out_ready = 1'b0;
      fork
         begin
            for (int n = 0; n < 8; n++) begin
               for (int i = 0; i < LANES; i++) begin
                  va[i*DW +: DW] = $urandom;
                  vb[i*DW +: DW] = $urandom;
               end
               applyStimulus((n % 2 == 0) ? 4'd1 : 4'd2, va, vb, 1'b0, $urandom, $urandom);
            end
         end
         begin
            for (int k = 0; k < 50 && out_valid !== 1'b1; k++) @(negedge clk);
            checkBit("stall_out_valid", out_valid, 1'b1);
            repeat (5) begin
               @(negedge clk);
               checkBit("stall_in_ready", in_ready, 1'b0);
            end
            @(posedge clk);
            #1;
            out_ready = 1'b1;
         end
      join
      idle(6);

      // Reset between MAC beats discards the accumulator
      applyStimulus(4'd3, v3, v4, 1'b0, 32'h0, 32'h0);
      idle(3);
      rst = 1'b0;
      #1;
      checkBit("midreset_out_valid", out_valid, 1'b0);
      checkBit("midreset_outputs_zero", (mul_res == '0) && (sum_res == '0) && (addr_res == '0)
               && (mac_beats == '0) && !op_err, 1'b1);
      checkBit("midreset_in_ready", in_ready, 1'b0);
      sb.delete();
      for (int i = 0; i < LANES; i++) model_acc[i] = '0;
      model_cnt = 0;
      idle(1);
      rst = 1'b1;
      idle(1);
      applyStimulus(4'd3, v3, v4, 1'b1, 32'h80, 32'h4);
      idle(8);

      checkBit("scoreboard_drained", sb.size() == 0, 1'b1);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
